// File: rtl/sha_mem_arbiter.sv
// sha_mem_arbiter: round-robin owner of the single message/hash memory port.
// One engine owns the port for a whole job (reads plus hash write-back); a
// hold watchdog reclaims the port from an engine that never releases it.
module sha_mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int HOLD_LIMIT = 2048
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_clk,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_write_data,
  input  logic [DATA_W-1:0]         mem_read_data,
  output logic                      hold_err
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (HOLD_LIMIT > 1) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_LIMIT > 0) ? CNT_W'(HOLD_LIMIT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_HANDOFF} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;     // last winner; also the current owner in OWN
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] blk_q, blk_d;     // engines evicted by the watchdog, until they drop req
  logic [NUM_REQ-1:0] elig;
  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;

  assign elig     = req & ~blk_q;
  assign gnt      = gnt_q;
  assign hold_err = err_q;
  assign rdata    = mem_read_data;
  assign mem_clk  = clk;

  // Round-robin search: first eligible engine starting just above the last winner.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_vld && elig[PTR_W'(idx)]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(idx);
      end
    end
  end

  // Ownership FSM: grant in IDLE, hold through OWN, one quiet HANDOFF cycle.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    blk_d   = blk_q & req;   // an evicted engine becomes eligible once it drops req
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = NUM_REQ'(1) << pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = '0;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (!req[ptr_q]) begin
          gnt_d   = '0;
          state_d = S_HANDOFF;
        end else if ((HOLD_LIMIT != 0) && (cnt_q == CNT_LAST)) begin
          gnt_d        = '0;
          err_d        = 1'b1;
          blk_d[ptr_q] = 1'b1;
          state_d      = S_HANDOFF;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;  // saturate so a disabled watchdog never wraps
        end
      end
      S_HANDOFF: begin
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any job and gives engine 0 first priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      blk_q   <= blk_d;
    end
  end

  // Memory-side mux: only the owner reaches the port, everything else is quiet.
  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (state_q == S_OWN) begin
      mem_we         = req_we[ptr_q] & req[ptr_q];
      mem_addr       = req_addr[ptr_q*ADDR_W +: ADDR_W];
      mem_write_data = req_wdata[ptr_q*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_sha_mem_arbiter.sv
// tb_sha_mem_arbiter: directed vectors for the memory-port arbiter.
module tb_sha_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req = '0;
  logic [3:0]   req_we = '0;
  logic [63:0]  req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   gnt;
  logic [31:0]  rdata;
  logic         mem_clk;
  logic         mem_we;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_write_data;
  logic [31:0]  mem_read_data = '0;
  logic         hold_err;

  int total = 0;
  int bad   = 0;

  sha_mem_arbiter #(.NUM_REQ(4), .ADDR_W(16), .DATA_W(32), .HOLD_LIMIT(16)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rdata(rdata),
    .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .hold_err(hold_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [3:0]  gnt;
    logic        mwe;
    logic [15:0] maddr;
    logic [31:0] mdata;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    req_we  = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int          order[5];
    int          n_own;
    logic [3:0]  oh;

    // engine slices: e3, e2, e1, e0
    req_addr  = {16'h3000, 16'h0010, 16'h0020, 16'h1000};
    req_wdata = {32'h33333333, 32'hDEADBEEF, 32'hBADBAD01, 32'h11111111};

    // single owner (engine 0), then engine 2 write with engine 1 contending
    tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 16'h1000, 32'h11111111};
    tbl[1] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 16'h1000, 32'h11111111};
    for (int i = 2; i <= 9; i++)
      tbl[i] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 16'h1000, 32'h11111111};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 32'h0};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 32'h0};
    tbl[12] = '{4'b0100, 4'b0000, 4'b0100, 1'b0, 16'h0010, 32'hDEADBEEF};
    tbl[13] = '{4'b0110, 4'b0110, 4'b0100, 1'b1, 16'h0010, 32'hDEADBEEF};
    tbl[14] = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 16'h0000, 32'h0};
    tbl[15] = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 16'h0000, 32'h0};
    tbl[16] = '{4'b0010, 4'b0010, 4'b0010, 1'b1, 16'h0020, 32'hBADBAD01};
    tbl[17] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 32'h0};
    tbl[18] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 16'h0000, 32'h0};

    do_reset();
    chk("reset gnt", 32'(gnt), 32'h0);
    chk("reset hold_err", 32'(hold_err), 32'h0);
    chk("reset mem_we", 32'(mem_we), 32'h0);
    chk("reset mem_addr", 32'(mem_addr), 32'h0);

    mem_read_data = 32'hCAFEF00D;
    #1 chk("rdata pass", rdata, 32'hCAFEF00D);
    mem_read_data = 32'h0BADC0DE;
    #1 chk("rdata pass2", rdata, 32'h0BADC0DE);

    for (int r = 0; r < 19; r++) begin
      req    = tbl[r].req;
      req_we = tbl[r].we;
      step();
      chk($sformatf("vec%0d gnt", r),   32'(gnt),      32'(tbl[r].gnt));
      chk($sformatf("vec%0d we", r),    32'(mem_we),   32'(tbl[r].mwe));
      chk($sformatf("vec%0d addr", r),  32'(mem_addr), 32'(tbl[r].maddr));
      chk($sformatf("vec%0d wdata", r), mem_write_data, tbl[r].mdata);
      chk($sformatf("vec%0d err", r),   32'(hold_err), 32'h0);
    end

    // all four request together; each releases after 5 owned cycles
    do_reset();
    order = '{0, 1, 2, 3, 0};
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      oh = 4'b0001 << order[j];
      step();
      chk($sformatf("rr grant%0d", j), 32'(gnt), 32'(oh));
      for (int c = 1; c < 5; c++) begin
        step();
        chk($sformatf("rr hold%0d", j), 32'(gnt), 32'(oh));
      end
      req[order[j]] = 1'b0;
      step();
      chk($sformatf("rr handoff%0d", j), 32'(gnt), 32'h0);
      chk($sformatf("rr handoff_we%0d", j), 32'(mem_we), 32'h0);
      req[order[j]] = 1'b1;
      step();
      chk($sformatf("rr idle%0d", j), 32'(gnt), 32'h0);
    end

    // watchdog: engine 3 hangs on the port
    do_reset();
    req = 4'b1000;
    n_own = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (gnt == 4'b1000) n_own++;
      if (c == 16) begin
        chk("wd last owned gnt", 32'(gnt), 32'h8);
        chk("wd err before", 32'(hold_err), 32'h0);
      end
      if (c == 17) begin
        chk("wd drop gnt", 32'(gnt), 32'h0);
        chk("wd err set", 32'(hold_err), 32'h1);
      end
    end
    chk("wd owned cycles", 32'(n_own), 32'd16);
    chk("wd no regrant", 32'(gnt), 32'h0);
    req = 4'b0000;
    step();
    chk("wd err sticky", 32'(hold_err), 32'h1);
    req    = 4'b1000;
    req_we = 4'b1000;
    step();
    chk("wd regrant", 32'(gnt), 32'h8);
    chk("wd regrant we", 32'(mem_we), 32'h1);
    chk("wd regrant addr", 32'(mem_addr), 32'h3000);
    step();
    chk("burst we", 32'(mem_we), 32'h1);

    // asynchronous reset in the middle of the write burst
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async rst gnt", 32'(gnt), 32'h0);
    chk("async rst we", 32'(mem_we), 32'h0);
    chk("async rst err", 32'(hold_err), 32'h0);
    chk("async rst addr", 32'(mem_addr), 32'h0);
    req    = 4'b1111;
    req_we = 4'b0000;
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
    chk("post rst prio0", 32'(gnt), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
